// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: FIFO-facing bundle between the VC arbiter and the two VC FIFOs plus the downstream FIFO.
interface vc_arbiter_if #(parameter int data_width = 6);
  logic                  empty_vc0, empty_vc1;
  logic                  error_vc0, error_vc1;
  logic [data_width-1:0] data_vc0, data_vc1;
  logic                  down_almost_full, down_full;
  logic                  fifo_init;
  logic [3:0]            umbral_vc0, umbral_vc1;
  logic                  rd_vc0, rd_vc1;
  logic                  wr_down;
  logic [data_width-1:0] data_down;
  modport master (
    input  empty_vc0, empty_vc1, error_vc0, error_vc1, data_vc0, data_vc1,
           down_almost_full, down_full,
    output fifo_init, umbral_vc0, umbral_vc1, rd_vc0, rd_vc1, wr_down, data_down
  );
  modport slave (
    output empty_vc0, empty_vc1, error_vc0, error_vc1, data_vc0, data_vc1,
           down_almost_full, down_full,
    input  fifo_init, umbral_vc0, umbral_vc1, rd_vc0, rd_vc1, wr_down, data_down
  );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin drain of VC0/VC1 into the downstream FIFO with config, stall and sticky error.
module vc_arbiter #(
  parameter int data_width = 6,
  parameter int weight_vc0 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [3:0]  umbral_vc0_in,
  input  logic [3:0]  umbral_vc1_in,
  vc_arbiter_if.master f,
  output logic [1:0]  state,
  output logic        error
);
  typedef enum logic [1:0] {RESET = 2'd0, INIT = 2'd1, IDLE = 2'd2, ACTIVE = 2'd3} state_t;
  localparam logic [3:0] w = 4'(weight_vc0);
  state_t                state_q, state_d;
  logic [3:0]            umbral_vc0_q, umbral_vc0_d, umbral_vc1_q, umbral_vc1_d;
  logic [3:0]            credit_q, credit_d;
  logic                  sel_q, sel_d, rd_q, rd_d, error_q, error_d;
  logic                  stall, run, ne0, ne1, live;
  logic [data_width-1:0] word;
  assign stall = f.down_almost_full | f.down_full;
  assign ne0   = !f.empty_vc0;
  assign ne1   = !f.empty_vc1;
  assign live  = state_q == IDLE || state_q == ACTIVE;
  assign run   = state_q == ACTIVE && !stall && !error_q;
  // credit counts remaining VC0 grants allowed while VC1 is waiting
  assign f.rd_vc0 = run && ne0 && (!ne1 || credit_q != 4'd0);
  assign f.rd_vc1 = run && ne1 && (!ne0 || credit_q == 4'd0);
  assign f.fifo_init  = live;
  assign f.umbral_vc0 = umbral_vc0_q;
  assign f.umbral_vc1 = umbral_vc1_q;
  assign f.wr_down    = rd_q && live;
  assign word         = sel_q ? f.data_vc1 : f.data_vc0;
  assign f.data_down  = f.wr_down ? word : '0;
  assign state        = state_q;
  assign error        = error_q;
  always_comb begin
    credit_d     = f.rd_vc1 ? w : (f.rd_vc0 && ne1) ? credit_q - 4'd1 : credit_q;
    rd_d         = f.rd_vc0 | f.rd_vc1;
    sel_d        = f.rd_vc1;
    umbral_vc0_d = state_q == INIT ? umbral_vc0_in : umbral_vc0_q;
    umbral_vc1_d = state_q == INIT ? umbral_vc1_in : umbral_vc1_q;
    error_d      = state_q == INIT ? 1'b0 : live ? (error_q | f.error_vc0 | f.error_vc1) : error_q;
    state_d      = state_q;
    case (state_q)
      RESET:   state_d = INIT;
      INIT:    state_d = init ? INIT : IDLE;
      IDLE:    state_d = init ? INIT : ((ne0 || ne1) && !stall && !error_q) ? ACTIVE : IDLE;
      default: state_d = init ? INIT : ((!ne0 && !ne1) || stall || error_q) ? IDLE : ACTIVE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RESET;
      umbral_vc0_q <= 4'd0;
      umbral_vc1_q <= 4'd0;
      credit_q     <= w;
      sel_q        <= 1'b0;
      rd_q         <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      umbral_vc0_q <= umbral_vc0_d;
      umbral_vc1_q <= umbral_vc1_d;
      credit_q     <= credit_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      error_q      <= error_d;
    end
  end
endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Read-side scheduler for the two virtual-channel FIFOs (VC0, VC1) of the transmission-layer datapath. It configures the FIFOs (init and almost-empty/almost-full thresholds), drains both channels with weighted round-robin (VC0 favoured), and forwards the popped words to the single downstream FIFO. It stalls whenever the downstream FIFO is almost full.

## Interface
- data_width, 6, word width of VC and downstream data
- weight_vc0, 3, consecutive VC0 grants allowed while VC1 is waiting (legal 1..15)
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- init  in  1  1 = (re)configure; holds block in INIT
- umbral_vc0_in, umbral_vc1_in  in  4  threshold values captured in INIT
- empty_vc0, empty_vc1  in  1  FIFO empty flags
- error_vc0, error_vc1  in  1  FIFO overflow flags
- data_vc0, data_vc1  in  data_width  FIFO data_out (registered in FIFO, valid one cycle after the rd pulse)
- down_almost_full, down_full  in  1  downstream FIFO status
- fifo_init  out  1  init to all FIFOs; 0 clears them
- umbral_vc0, umbral_vc1  out  4  registered thresholds to the FIFOs
- rd_vc0, rd_vc1  out  1  pop strobes (combinational)
- wr_down  out  1  downstream write strobe (registered)
- data_down  out  data_width  word to the downstream FIFO
- state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
- error  out  1  sticky error flag

## Operation
- reset=0 at an edge forces the following values: state=RESET, umbral_*=0, credit=weight_vc0, sel_q=0, rd_q=0, error=0. Consequently fifo_init=0, wr_down=0 and rd_*=0.
- State transitions:
  - RESET -> INIT on the first edge with reset=1.
  - INIT: umbral_* <= umbral_*_in every cycle and error <= 0. Go to IDLE when init=0.
  - IDLE -> ACTIVE when (!empty_vc0 | !empty_vc1) & !stall & !error.
  - ACTIVE -> IDLE when both FIFOs are empty, or when stall or error is set.
  - IDLE or ACTIVE -> INIT whenever init=1. This has priority over every other transition.
- fifo_init = 1 only in IDLE and ACTIVE.
- stall = down_almost_full | down_full.
- Pops occur only when state==ACTIVE & !stall & !error. At most one of rd_vc0/rd_vc1 is high in any cycle.
- Grant rules:
  - Only VC0 non-empty: grant VC0; credit is unchanged.
  - Only VC1 non-empty: grant VC1; credit reloads to weight_vc0.
  - Both non-empty, credit>0: grant VC0 and decrement credit.
  - Both non-empty, credit==0: grant VC1 and reload credit.
- credit is 4 bits. It never underflows and never exceeds weight_vc0.
- Registered on every edge: rd_q <= rd_vc0|rd_vc1 and sel_q <= rd_vc1.
- Forwarding path:
  - wr_down = rd_q & (state is IDLE or ACTIVE).
  - data_down = sel_q ? data_vc1 : data_vc0 when wr_down=1; otherwise 0.
- error <= 1 when error_vc0|error_vc1 in IDLE or ACTIVE. It is cleared only by reset or by INIT.

## Timing
- A pop in cycle N produces wr_down=1 with the popped word in cycle N+1. Fixed latency 1. Back-to-back pops give one word per cycle.
- The stall decision is combinational on the same cycle's flags, so at most one word is in flight after down_almost_full rises. The downstream threshold must leave ≥1 free slot.
- Empty flags update the cycle after a pop, so the last word of a FIFO is popped exactly once. No pop ever occurs with empty_* =1.
- init asserted in cycle N during ACTIVE:
  - rd_* drop in cycle N+1 (the state is then INIT).
  - A word popped in N has wr_down suppressed in N+1 and is discarded (all FIFOs flush).
- reset mid-operation takes effect at the next edge. There is no output activity in the following cycle.

## Test plan
- Reset/config:
  - Stimulus: reset=0 for 2 cycles, then reset=1, init=1, umbral_vc0_in=4, umbral_vc1_in=2 for 3 cycles, then init=0.
  - Required: state 0->1->2, umbral_vc0=4, umbral_vc1=2, fifo_init rises in the IDLE cycle, all strobes 0 throughout.
- Weighted RR:
  - Stimulus: VC0 holds 8 words, VC1 holds 8 words, no stall, weight_vc0=3.
  - Required: pop sequence 0,0,0,1,0,0,0,1,0,0,0,1,…. Each data_down matches its source one cycle after the pop.
- Single channel:
  - Stimulus: only VC1 holds 5 words.
  - Required: 5 consecutive rd_vc1 pulses, 5 wr_down pulses, return to IDLE, no pop on empty.
- Backpressure:
  - Stimulus: down_almost_full raised mid-burst for 4 cycles.
  - Required: rd_* =0 on the same cycle, at most 1 trailing wr_down, state IDLE, then drain resumes with order preserved.
- Init mid-burst:
  - Stimulus: init=1 during ACTIVE.
  - Required: state=INIT next cycle, wr_down=0 there, fifo_init=0, credit unchanged until IDLE.
- Error:
  - Stimulus: pulse error_vc0 for 1 cycle.
  - Required: error=1 sticky, pops stop, state IDLE. A subsequent init pulse clears error.
